argmax_reader: RTL
==================

Name: argmax_reader

Overview:
Consumer end of the final-layer output buffer. It reads the packed VEC-lane words that the last fully connected layer writes into its output BRAM and unpacks each lane. It then scans the OUTPUT_DEPTH signed fixed-point scores and reports the winning class index and its score. It sits after the MLP sequencer and is triggered by the MLP done pulse, so the testbench no longer has to reach into the BRAM hierarchically.

Parameters:
DATA_WIDTH, 16, width of one signed fixed-point element.
VEC, 16, elements packed per BRAM word.
OUTPUT_DEPTH, 10, number of valid scores (classes).
VEC_DEPTH, (OUTPUT_DEPTH+VEC-1)/VEC, localparam: number of BRAM words read.
ADDR_WIDTH, max(1,clog2(VEC_DEPTH)), localparam: BRAM read-address width.
CLASS_WIDTH, max(1,clog2(OUTPUT_DEPTH)), localparam: class-index width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a scan; sampled only in IDLE.
rden  out  1  BRAM read enable.
rdaddr  out  ADDR_WIDTH  BRAM read address (word index).
q  in  VEC*DATA_WIDTH  BRAM read data; valid 1 cycle after rden/rdaddr.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when result is updated.
result_valid  out  1  high from done until the next accepted start.
class_idx  out  CLASS_WIDTH  index of the maximum score.
max_value  out  DATA_WIDTH  signed maximum score.

Behaviour:
- Reset (rst_n low, async): state IDLE; rden, rdaddr, busy, done, result_valid, class_idx, max_value, and all internal counters/registers are 0.
- Lane mapping: lane i is q[i*DATA_WIDTH +: DATA_WIDTH]. Element index = word*VEC + i. All comparisons are signed two's complement.
- States:
  - IDLE: start=1 → FETCH. Clear result_valid, word counter and element counter.
  - FETCH: rden=1, rdaddr=word counter, for exactly 1 cycle → WAIT.
  - WAIT: q is valid this cycle. Capture q into a lane register, set lane counter to 0 → SCAN.
  - SCAN: one lane per cycle. Element 0 loads the running max and index unconditionally. Any later element replaces them only if strictly greater, so ties resolve to the lowest index. On the last element (index OUTPUT_DEPTH-1) → DONE. On the last lane of a word that is not the last element, increment the word counter → FETCH.
  - DONE: load class_idx/max_value from the running registers. Pulse done=1 for one cycle, set result_valid=1 → IDLE.
- Lanes beyond OUTPUT_DEPTH in the final partial word are never compared.
- Latency: start sampled at edge 0 → done high in cycle 2*VEC_DEPTH + OUTPUT_DEPTH + 1. Defaults: cycle 13.
- rden is high only in FETCH. rdaddr holds its last value outside FETCH.
- start while busy, including in DONE, is ignored. A start asserted in the same cycle done is high is ignored. A new scan needs start in IDLE.
- class_idx/max_value hold their values between scans. They change only in DONE.
- Reset mid-scan: immediate return to IDLE with all outputs 0. No done pulse follows.
- Only the scores are read; the block never writes the BRAM.

Test Plan:
- Defaults; scores 0x0010,0x0020,...,0x00A0 with lane 7 = 0x0500 → done at cycle 13, class_idx=7, max_value=0x0500, rden high exactly 1 cycle, rdaddr=0.
- Tie: lanes 2 and 5 both 0x0300, others 0x0100 → class_idx=2.
- All negative: scores -0x0100 down to -0x0A00 (element i = -(i+1)*0x100) → class_idx=0, max_value=0xFF00.
- OUTPUT_DEPTH=20, VEC=16; word1 lane 3 = 0x0400, word1 lane 5 = 0x7FFF (outside depth) → class_idx=19, max_value=0x0400, done at cycle 25, reads at addr 0 then 1.
- start pulsed again in cycles 3 and 13 of a scan → single done pulse, result unchanged. Next start in IDLE → result_valid drops the next cycle, then rescan succeeds.
- rst_n low during SCAN → all outputs 0 immediately, no done. Then start → correct result.

Source files
------------

// File: rtl/argmax_reader.sv
// Reads packed score words from the final-layer output BRAM, unpacks the lanes one
// per cycle and reports the index and value of the largest signed score.
module argmax_reader #(
    parameter  int DATA_WIDTH   = 16,
    parameter  int VEC          = 16,
    parameter  int OUTPUT_DEPTH = 10,
    localparam int VEC_DEPTH    = (OUTPUT_DEPTH + VEC - 1) / VEC,
    localparam int ADDR_WIDTH   = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1,
    localparam int CLASS_WIDTH  = (OUTPUT_DEPTH > 1) ? $clog2(OUTPUT_DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      rden,
    output logic [ADDR_WIDTH-1:0]     rdaddr,
    input  logic [VEC*DATA_WIDTH-1:0] q,
    output logic                      busy,
    output logic                      done,
    output logic                      result_valid,
    output logic [CLASS_WIDTH-1:0]    class_idx,
    output logic [DATA_WIDTH-1:0]     max_value
);

    localparam int LANE_WIDTH = (VEC > 1) ? $clog2(VEC) : 1;
    localparam logic [LANE_WIDTH-1:0]  LAST_LANE = LANE_WIDTH'(VEC - 1);
    localparam logic [CLASS_WIDTH-1:0] LAST_ELEM = CLASS_WIDTH'(OUTPUT_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     word_q, word_d;
    logic [CLASS_WIDTH-1:0]    elem_q, elem_d;
    logic [LANE_WIDTH-1:0]     lane_q, lane_d;
    logic [VEC*DATA_WIDTH-1:0] lanes_q, lanes_d;
    logic [DATA_WIDTH-1:0]     run_max_q, run_max_d;
    logic [CLASS_WIDTH-1:0]    run_idx_q, run_idx_d;
    logic                      rden_q, rden_d;
    logic [ADDR_WIDTH-1:0]     rdaddr_q, rdaddr_d;
    logic                      done_q, done_d;
    logic                      result_valid_q, result_valid_d;
    logic [CLASS_WIDTH-1:0]    class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0]     max_value_q, max_value_d;
    logic [DATA_WIDTH-1:0]     cur_lane;

    // The lane register shifts down each scan cycle, so the current lane is always lane 0.
    assign cur_lane = lanes_q[DATA_WIDTH-1:0];

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        elem_d         = elem_q;
        lane_d         = lane_q;
        lanes_d        = lanes_q;
        run_max_d      = run_max_q;
        run_idx_d      = run_idx_q;
        rdaddr_d       = rdaddr_q;
        result_valid_d = result_valid_q;
        class_idx_d    = class_idx_q;
        max_value_d    = max_value_q;
        rden_d         = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_FETCH;
                    result_valid_d = 1'b0;
                    word_d         = '0;
                    elem_d         = '0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                lanes_d = q;
                lane_d  = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                lanes_d = lanes_q >> DATA_WIDTH;
                // Strict greater-than keeps the lowest index on ties.
                if (elem_q == '0 || $signed(cur_lane) > $signed(run_max_q)) begin
                    run_max_d = cur_lane;
                    run_idx_d = elem_q;
                end
                if (elem_q == LAST_ELEM) begin
                    state_d = S_DONE;
                end else begin
                    elem_d = elem_q + CLASS_WIDTH'(1);
                    if (lane_q == LAST_LANE) begin
                        word_d  = word_q + ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end else begin
                        lane_d = lane_q + LANE_WIDTH'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered on entry to the state that owns them.
        if (state_d == S_FETCH) begin
            rden_d   = 1'b1;
            rdaddr_d = word_d;
        end
        if (state_d == S_DONE) begin
            done_d         = 1'b1;
            result_valid_d = 1'b1;
            class_idx_d    = run_idx_d;
            max_value_d    = run_max_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            word_q         <= '0;
            elem_q         <= '0;
            lane_q         <= '0;
            lanes_q        <= '0;
            run_max_q      <= '0;
            run_idx_q      <= '0;
            rden_q         <= 1'b0;
            rdaddr_q       <= '0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            class_idx_q    <= '0;
            max_value_q    <= '0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            elem_q         <= elem_d;
            lane_q         <= lane_d;
            lanes_q        <= lanes_d;
            run_max_q      <= run_max_d;
            run_idx_q      <= run_idx_d;
            rden_q         <= rden_d;
            rdaddr_q       <= rdaddr_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            class_idx_q    <= class_idx_d;
            max_value_q    <= max_value_d;
        end
    end

    assign rden         = rden_q;
    assign rdaddr       = rdaddr_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign class_idx    = class_idx_q;
    assign max_value    = max_value_q;

endmodule
